// File: rtl/rf_wb_queue.sv
// rtl/rf_wb_queue.sv - register file write-back queue: merges two sources, zero-sweeps on reset,
// drains one entry per cycle and forwards queued data onto the read ports.
module rf_wb_queue #(
  parameter int WSIZE   = 32,
  parameter int RCOUNT  = 32,
  parameter int R0_ZERO = 1,
  parameter int DEPTH   = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             P0_VALID,
  output logic             P0_READY,
  input  logic [4:0]       P0_ADDR,
  input  logic [WSIZE-1:0] P0_DATA,
  input  logic             P1_VALID,
  output logic             P1_READY,
  input  logic [4:0]       P1_ADDR,
  input  logic [WSIZE-1:0] P1_DATA,
  output logic             RF_WE,
  output logic [4:0]       RF_RW,
  output logic [WSIZE-1:0] RF_DW,
  input  logic [4:0]       RA,
  input  logic [4:0]       RB,
  input  logic [WSIZE-1:0] RF_DA,
  input  logic [WSIZE-1:0] RF_DB,
  output logic [WSIZE-1:0] DA,
  output logic [WSIZE-1:0] DB,
  output logic             INIT_DONE
);

  localparam int AW = $clog2(DEPTH);
  localparam bit DROP_R0 = (R0_ZERO != 0);
  localparam logic [4:0]  CNT_INIT = DROP_R0 ? 5'd1 : 5'd0;
  localparam logic [4:0]  CNT_LAST = 5'(RCOUNT - 1);
  localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] OCC_PAIR = (AW+1)'(DEPTH - 1);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [AW:0]       occ_q, occ_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [4:0]        addr_q [DEPTH];
  logic [4:0]        addr_d [DEPTH];
  logic [WSIZE-1:0]  data_q [DEPTH];
  logic [WSIZE-1:0]  data_d [DEPTH];

  logic              run;
  logic              p0_push, p1_push, pop;
  logic [AW-1:0]     wr_idx;
  logic [AW-1:0]     fwd_idx;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_INIT;
      cnt_q    <= CNT_INIT;
      occ_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      occ_q    <= occ_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge CLK) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == S_INIT && cnt_q == CNT_LAST) state_d = S_RUN;
  end

  always_comb begin
    run       = (state_q == S_RUN);
    INIT_DONE = run;
    P0_READY  = run && (occ_q < OCC_FULL);
    P1_READY  = run && (occ_q < OCC_PAIR);
    RF_WE     = run ? (occ_q != '0) : 1'b1;
    RF_RW     = run ? addr_q[rd_ptr_q] : cnt_q;
    RF_DW     = run ? data_q[rd_ptr_q] : '0;
  end

  // Accepted writes to r0 are consumed without occupying a slot.
  always_comb begin
    p0_push = P0_VALID && P0_READY && !(DROP_R0 && P0_ADDR == 5'd0);
    p1_push = P1_VALID && P1_READY && !(DROP_R0 && P1_ADDR == 5'd0);
    pop     = run && (occ_q != '0);
    cnt_d   = run ? cnt_q : cnt_q + 5'd1;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_idx  = wr_ptr_q;
    if (p0_push) begin
      addr_d[wr_idx] = P0_ADDR;
      data_d[wr_idx] = P0_DATA;
      wr_idx         = wr_idx + AW'(1);
    end
    if (p1_push) begin
      addr_d[wr_idx] = P1_ADDR;
      data_d[wr_idx] = P1_DATA;
      wr_idx         = wr_idx + AW'(1);
    end
    wr_ptr_d = wr_idx;
    rd_ptr_d = rd_ptr_q + AW'(pop);
    occ_d    = occ_q + (AW+1)'(p0_push) + (AW+1)'(p1_push) - (AW+1)'(pop);
  end

  // Scan oldest to youngest so the youngest matching entry wins.
  always_comb begin
    DA      = run ? RF_DA : '0;
    DB      = run ? RF_DB : '0;
    fwd_idx = rd_ptr_q;
    if (run) begin
      for (int i = 0; i < DEPTH; i++) begin
        fwd_idx = rd_ptr_q + AW'(i);
        if ((AW+1)'(i) < occ_q) begin
          if (addr_q[fwd_idx] == RA) DA = data_q[fwd_idx];
          if (addr_q[fwd_idx] == RB) DB = data_q[fwd_idx];
        end
      end
    end
  end

endmodule
